// File: rtl/rgb_arb_pkg.sv
// rgb_arb_pkg
//   Shared definitions for the colour-lookup arbiter: FSM state encoding,
//   colour/RGB widths, named 3-bit colour codes (bit2=R, bit1=G, bit0=B)
//   and their 24-bit RGB values, plus a helper that maps a code to its RGB
//   word (used to preload the lookup BRAM image).
package rgb_arb_pkg;

  localparam int COL_W = 3;
  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef logic [1:0] req_vec_t;

  localparam logic [COL_W-1:0] COL_BLACK   = 3'b000;
  localparam logic [COL_W-1:0] COL_BLUE    = 3'b001;
  localparam logic [COL_W-1:0] COL_GREEN   = 3'b010;
  localparam logic [COL_W-1:0] COL_CYAN    = 3'b011;
  localparam logic [COL_W-1:0] COL_RED     = 3'b100;
  localparam logic [COL_W-1:0] COL_MAGENTA = 3'b101;
  localparam logic [COL_W-1:0] COL_YELLOW  = 3'b110;
  localparam logic [COL_W-1:0] COL_WHITE   = 3'b111;

  localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;
  localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;

  function automatic logic [RGB_W-1:0] colour_rgb(input logic [COL_W-1:0] col);
    logic [RGB_W-1:0] rgb;
    rgb = RGB_BLACK;
    case (col)
      COL_BLACK:   rgb = RGB_BLACK;
      COL_BLUE:    rgb = RGB_BLUE;
      COL_GREEN:   rgb = RGB_GREEN;
      COL_CYAN:    rgb = RGB_CYAN;
      COL_RED:     rgb = RGB_RED;
      COL_MAGENTA: rgb = RGB_MAGENTA;
      COL_YELLOW:  rgb = RGB_YELLOW;
      COL_WHITE:   rgb = RGB_WHITE;
      default:     rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/rgb_arb_grant.sv
// rgb_arb_grant
//   Two-way request arbiter producing a one-hot grant.
//   Build option RGB_ARB_RR_EN:
//     defined   - round-robin; ptr_i names the preferred requester.
//     undefined - fixed priority, requester 0 wins ties; no pointer port.
// Ports:
//   req_i  [1:0] request vector
//   ptr_i        preferred requester (RGB_ARB_RR_EN only)
//   gnt_o  [1:0] one-hot grant, zero when no request
//   idx_o        index of the granted requester (0 when no grant)
module rgb_arb_grant
  import rgb_arb_pkg::*;
(
  input  req_vec_t req_i,
`ifdef RGB_ARB_RR_EN
  input  logic     ptr_i,
`endif
  output req_vec_t gnt_o,
  output logic     idx_o
);

`ifdef RGB_ARB_RR_EN
  always_comb begin
    gnt_o = '0;
    if (req_i[ptr_i]) begin
      gnt_o[ptr_i] = 1'b1;
    end else if (req_i[~ptr_i]) begin
      gnt_o[~ptr_i] = 1'b1;
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end
`endif

  assign idx_o = gnt_o[1];

endmodule

// File: rtl/rgb_lookup_arbiter.sv
// rgb_lookup_arbiter
//   Shares the single-port 8x24 colour-lookup BRAM between two requesters.
//   One lookup is in flight at a time: accept a request, pulse the BRAM read
//   enable for one cycle, wait out the read latency, then hold the captured
//   RGB word on a valid/ready response to the granted requester.
//   Build option RGB_ARB_RR_EN selects round-robin arbitration (default is
//   fixed priority, requester 0 first).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | offer req_ready to the granted requester, latch colour/grant
//   READ  | bram_en high for one cycle, load latency down-counter
//   WAIT  | count down; at terminal count capture bram_dout
//   RESP  | rsp_valid to granted requester until its rsp_ready
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready [1:0]  request handshake per requester
//   req_colour0/1 [COL_W-1:0]  colour code per requester
//   rsp_valid/rsp_ready [1:0]  response handshake per requester
//   rsp_rgb [RGB_W-1:0]        looked-up RGB word (shared)
//   bram_en, bram_addr         BRAM read port control
//   bram_dout [RGB_W-1:0]      BRAM read data, BRAM_LAT cycles after bram_en
module rgb_lookup_arbiter #(
  parameter int BRAM_LAT = 1,
  parameter int COL_W    = 3,
  parameter int RGB_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [COL_W-1:0] req_colour0,
  input  logic [COL_W-1:0] req_colour1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [RGB_W-1:0] rsp_rgb,
  output logic             bram_en,
  output logic [COL_W-1:0] bram_addr,
  input  logic [RGB_W-1:0] bram_dout
);
  import rgb_arb_pkg::state_t;
  import rgb_arb_pkg::IDLE;
  import rgb_arb_pkg::READ;
  import rgb_arb_pkg::WAIT;
  import rgb_arb_pkg::RESP;

  // Latency counter holds BRAM_LAT-1, at most 3.
  localparam int CNT_W = 2;

  state_t           state_q, state_d;
  logic [COL_W-1:0] addr_q, addr_d;
  logic             g_q, g_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic [1:0]       gnt;
  logic             gnt_idx;

`ifdef RGB_ARB_RR_EN
  logic ptr_q, ptr_d;
  logic accept;

  rgb_arb_grant u_grant (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Preference flips to the requester that was not just served.
  assign accept = (state_q == IDLE) && (|req_ready);
  assign ptr_d  = accept ? ~gnt_idx : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  rgb_arb_grant u_grant (
    .req_i (req_valid),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    rgb_d     = rgb_q;
    req_ready = '0;
    rsp_valid = '0;
    bram_en   = 1'b0;

    case (state_q)
      IDLE: begin
        // req_ready is combinational; keep it low while reset is held.
        req_ready = gnt & {2{rst_n}};
        if (|req_ready) begin
          g_d     = gnt_idx;
          addr_d  = gnt_idx ? req_colour1 : req_colour0;
          state_d = READ;
        end
      end
      READ: begin
        bram_en = 1'b1;
        cnt_d   = CNT_W'(BRAM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rgb_d   = bram_dout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = g_q ? 2'b10 : 2'b01;
        if (rsp_ready[g_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      g_q     <= 1'b0;
      cnt_q   <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      rgb_q   <= rgb_d;
    end
  end

  // Address register doubles as the BRAM address so it holds when idle.
  assign bram_addr = addr_q;
  assign rsp_rgb   = rgb_q;

endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
module tb_rgb_lookup_arbiter;
  import rgb_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // DUT with BRAM_LAT = 1
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_colour0, req_colour1, bram_addr;
  logic [23:0] rsp_rgb, bram_dout;
  logic        bram_en;

  // DUT with BRAM_LAT = 3
  logic [1:0]  req_valid_3, req_ready_3, rsp_valid_3, rsp_ready_3;
  logic [2:0]  req_colour0_3, req_colour1_3, bram_addr_3;
  logic [23:0] rsp_rgb_3, bram_dout_3;
  logic        bram_en_3;

  rgb_lookup_arbiter #(.BRAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_colour0(req_colour0), .req_colour1(req_colour1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rgb(rsp_rgb),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout)
  );

  rgb_lookup_arbiter #(.BRAM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_colour0(req_colour0_3), .req_colour1(req_colour1_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_rgb(rsp_rgb_3),
    .bram_en(bram_en_3), .bram_addr(bram_addr_3), .bram_dout(bram_dout_3)
  );

  // BRAM models: data is present only in the single cycle it is due.
  logic [23:0] s1_3, s2_3;
  always @(posedge clk) begin
    bram_dout   <= bram_en ? colour_rgb(bram_addr) : 24'h0;
    s1_3        <= bram_en_3 ? colour_rgb(bram_addr_3) : 24'h0;
    s2_3        <= s1_3;
    bram_dout_3 <= s2_3;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input logic [2:0] c);
    logic [23:0] r;
    r = 24'h0;
    case (c)
      3'b000: r = 24'h000000;
      3'b001: r = 24'h0000FF;
      3'b010: r = 24'h00FF00;
      3'b011: r = 24'h00FFFF;
      3'b100: r = 24'hFF0000;
      3'b101: r = 24'hFF00FF;
      3'b110: r = 24'hFFFF00;
      3'b111: r = 24'hFFFFFF;
      default: r = 24'h0;
    endcase
    return r;
  endfunction

  // Scoreboard for the BRAM_LAT=1 instance.
  typedef struct packed {
    logic [1:0]  who;
    logic [23:0] rgb;
  } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if ((req_valid & req_ready) != 2'b00) begin
        chk("req_ready_onehot", $countones(req_ready), 1);
        sb.push_back({req_ready, ref_rgb(req_ready[1] ? req_colour1 : req_colour0)});
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {30'b0, rsp_valid}, 0);
        end else begin
          sb_e = sb.pop_front();
          chk("rsp_who", {30'b0, rsp_valid}, {30'b0, sb_e.who});
          chk("rsp_rgb", {8'b0, rsp_rgb}, {8'b0, sb_e.rgb});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int          n_rsp;
  logic [1:0]  order [8];
  int          en_cnt;
  int          first;
  logic [23:0] got_rgb;
  logic [1:0]  got_v;

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11; req_colour0 = 3'b000; req_colour1 = 3'b000; rsp_ready = 2'b00;
    req_valid_3 = 2'b00; req_colour0_3 = 3'b000; req_colour1_3 = 3'b000; rsp_ready_3 = 2'b00;

    // Reset state
    mid();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rgb", rsp_rgb, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    tick(); req_valid = 2'b00; rst_n = 1'b1;
    tick(); tick();

    // Requester 0 alone, red
    rsp_ready = 2'b11; req_valid = 2'b01; req_colour0 = 3'b100;
    mid(); chk("t2_req_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    mid(); chk("t2_bram_en", bram_en, 1); chk("t2_bram_addr", bram_addr, 3'b100);
    tick();
    mid(); chk("t2_wait_rsp_valid", rsp_valid, 0); chk("t2_wait_bram_en", bram_en, 0);
    tick();
    mid(); chk("t2_rsp_valid", rsp_valid, 2'b01); chk("t2_rsp_rgb", rsp_rgb, 24'hFF0000);
    tick();
    mid(); chk("t2_after_rsp", rsp_valid, 0);

    // Reset in the middle of RESP
    tick(); req_valid = 2'b10; req_colour1 = 3'b110; rsp_ready = 2'b00;
    tick(); req_valid = 2'b00;
    tick(); tick();
    mid(); chk("rr_pre_rsp_valid", rsp_valid, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_rsp_rgb", rsp_rgb, 0);
    chk("rr_bram_en", bram_en, 0);
    mid();
    tick(); rst_n = 1'b1; rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      mid(); chk("rr_no_stale", rsp_valid, 0);
    end

    // Both requesters continuously valid
    tick(); rsp_ready = 2'b11; req_valid = 2'b11; req_colour0 = 3'b010; req_colour1 = 3'b001;
    n_rsp = 0;
    for (int i = 0; i < 16; i++) begin
      mid();
      if ((rsp_valid & rsp_ready) != 2'b00 && n_rsp < 8) begin
        order[n_rsp] = rsp_valid;
        n_rsp++;
      end
      tick();
    end
    req_valid = 2'b00;
    chk("t3_rsp_count", n_rsp, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef RGB_ARB_RR_EN
      chk("t3_order", order[k], (k % 2 == 1) ? 2'b10 : 2'b01);
`else
      chk("t3_order", order[k], 2'b01);
`endif
    end
    tick(); tick();

    // Back-pressure: rsp_ready low, wrong-bit pulse ignored
    req_valid = 2'b10; req_colour1 = 3'b110; rsp_ready = 2'b00;
    tick(); req_valid = 2'b01; req_colour0 = 3'b100;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i == 2) ? 2'b01 : 2'b00;
      mid();
      chk("t4_rsp_valid", rsp_valid, 2'b10);
      chk("t4_rsp_rgb", rsp_rgb, 24'hFFFF00);
      chk("t4_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 2'b10; req_valid = 2'b00;
    mid(); chk("t4_release_valid", rsp_valid, 2'b10);
    tick();
    mid(); chk("t4_after_release", rsp_valid, 0);
    tick();

    // Colour changed right after acceptance
    rsp_ready = 2'b11; req_valid = 2'b01; req_colour0 = 3'b101;
    mid(); chk("t6_req_ready", req_ready, 2'b01);
    tick(); req_colour0 = 3'b000; req_valid = 2'b00;
    mid(); chk("t6_bram_en", bram_en, 1); chk("t6_bram_addr", bram_addr, 3'b101);
    tick(); tick();
    mid(); chk("t6_rsp_valid", rsp_valid, 2'b01); chk("t6_rsp_rgb", rsp_rgb, 24'hFF00FF);
    tick();
    mid(); chk("t6_addr_hold", bram_addr, 3'b101);

    // BRAM_LAT = 3 instance, white
    tick(); req_valid_3 = 2'b01; req_colour0_3 = 3'b111; rsp_ready_3 = 2'b11;
    mid(); chk("t5_req_ready", req_ready_3, 2'b01);
    en_cnt = 0; first = -1; got_rgb = 24'h0; got_v = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) req_valid_3 = 2'b00;
      mid();
      if (bram_en_3) en_cnt++;
      if (rsp_valid_3 != 2'b00 && first < 0) begin
        first = i; got_rgb = rsp_rgb_3; got_v = rsp_valid_3;
      end
    end
    chk("t5_bram_en_pulses", en_cnt, 1);
    chk("t5_rsp_cycle", first, 5);
    chk("t5_rsp_rgb", got_rgb, 24'hFFFFFF);
    chk("t5_rsp_valid", got_v, 2'b01);

    tick(); tick();
    mid(); chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
